// File: rtl/wr_buffer_pkg.sv
// ----------------------------------------------------------------------------
// wr_buffer_pkg
//   Shared definitions for the posted store buffer: store size codes,
//   byte-enable constants and the drain FSM state encoding.
// ----------------------------------------------------------------------------
package wr_buffer_pkg;

    // Store size codes as presented on WB_Size
    localparam logic [1:0] WB_SZ_BYTE = 2'b00;
    localparam logic [1:0] WB_SZ_HALF = 2'b01;
    localparam logic [1:0] WB_SZ_WORD = 2'b10;
    localparam logic [1:0] WB_SZ_RSVD = 2'b11;

    // Byte-enable patterns, bit i = byte lane i (little-endian)
    localparam logic [3:0] WB_BE_NONE    = 4'b0000;
    localparam logic [3:0] WB_BE_BYTE    = 4'b0001;
    localparam logic [3:0] WB_BE_LO_HALF = 4'b0011;
    localparam logic [3:0] WB_BE_HI_HALF = 4'b1100;
    localparam logic [3:0] WB_BE_WORD    = 4'b1111;

    // Drain FSM states
    typedef enum logic {
        WB_IDLE = 1'b0,
        WB_REQ  = 1'b1
    } wb_state_e;

    // Reserved size is stored as a word but flagged as an error
    function automatic logic size_is_rsvd(input logic [1:0] size);
        return size == WB_SZ_RSVD;
    endfunction

endpackage

// File: rtl/wr_buffer_format.sv
// ----------------------------------------------------------------------------
// wr_buffer_format
//   Combinational lane replicator and byte-enable generator. Stores are
//   formatted once at push time so the buffer holds memory-ready entries.
//
//   Ports
//     addr_lo   in   2   low address bits (byte offset within the word)
//     size      in   2   store size code
//     data      in   32  right-justified store data
//     data_fmt  out  32  lane-replicated data
//     be        out  4   byte enables
// ----------------------------------------------------------------------------
module wr_buffer_format
    import wr_buffer_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic [31:0] data,
    output logic [31:0] data_fmt,
    output logic [3:0]  be
);

    always_comb begin
        data_fmt = data;
        be       = WB_BE_WORD;
        case (size)
            WB_SZ_BYTE: begin
                data_fmt = {4{data[7:0]}};
                be       = WB_BE_BYTE << addr_lo;
            end
            WB_SZ_HALF: begin
                // addr_lo[0] is ignored: halfwords are forced to lane pairs
                data_fmt = {2{data[15:0]}};
                be       = addr_lo[1] ? WB_BE_HI_HALF : WB_BE_LO_HALF;
            end
            default: begin
                // word and reserved: data as-is, all lanes enabled
                data_fmt = data;
                be       = WB_BE_WORD;
            end
        endcase
    end

endmodule

// File: rtl/wr_buffer.sv
// ----------------------------------------------------------------------------
// wr_buffer
//   Posted store buffer. Captures core stores, formats them to byte lanes and
//   drains them in order to external memory over a req/ack handshake. The
//   core only stalls on WB_Full and waits for WB_Empty before loads.
//
//   Ports
//     sysclk    in   1   system clock
//     reset     in   1   synchronous active-high reset
//     WB_Push   in   1   store request, Addr/Data/Size valid this cycle
//     WB_Addr   in   AW  store byte address
//     WB_Data   in   DW  right-justified store data
//     WB_Size   in   2   00 byte, 01 half, 10 word, 11 reserved (word + error)
//     WB_Full   out  1   buffer holds DEPTH entries
//     WB_Empty  out  1   nothing buffered and nothing in flight
//     WB_Err    out  1   sticky: push while full or reserved size
//     MEM_Req   out  1   memory write request
//     MEM_Addr  out  AW  word-aligned address of head entry
//     MEM_Data  out  DW  lane-replicated head data
//     MEM_BE    out  4   head byte enables
//     MEM_Ack   in   1   memory accepted the current request
//
//   FSM states
//     state    | meaning
//     ---------+-------------------------------------------------------
//     WB_IDLE  | no request outstanding; leaves when an entry is held
//     WB_REQ   | MEM_Req high, head entry presented until MEM_Ack
// ----------------------------------------------------------------------------
module wr_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic          sysclk,
    input  logic          reset,
    input  logic          WB_Push,
    input  logic [AW-1:0] WB_Addr,
    input  logic [DW-1:0] WB_Data,
    input  logic [1:0]    WB_Size,
    output logic          WB_Full,
    output logic          WB_Empty,
    output logic          WB_Err,
    output logic          MEM_Req,
    output logic [AW-1:0] MEM_Addr,
    output logic [DW-1:0] MEM_Data,
    output logic [3:0]    MEM_BE,
    input  logic          MEM_Ack
);
    import wr_buffer_pkg::*;

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    // Entry storage, kept as parallel arrays (address, data, byte enables)
    logic [AW-1:0] ent_addr [DEPTH];
    logic [DW-1:0] ent_data [DEPTH];
    logic [3:0]    ent_be   [DEPTH];

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    wb_state_e     state;
    logic          err;

    logic          full;
    logic          push_ok;
    logic          pop;
    logic [DW-1:0] fmt_data;
    logic [3:0]    fmt_be;

    wr_buffer_format u_format (
        .addr_lo  (WB_Addr[1:0]),
        .size     (WB_Size),
        .data     (WB_Data),
        .data_fmt (fmt_data),
        .be       (fmt_be)
    );

    // Full is taken from the pre-edge count, so a push into a full buffer is
    // dropped even when the head pops on the same edge.
    assign full    = (count == CW'(DEPTH));
    assign push_ok = WB_Push & ~full;
    assign pop     = (state == WB_REQ) & MEM_Ack;

    always_comb begin
        count_next = count;
        case ({push_ok, pop})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            state  <= WB_IDLE;
            err    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_addr[i] <= '0;
                ent_data[i] <= '0;
                ent_be[i]   <= WB_BE_NONE;
            end
        end else begin
            if (push_ok) begin
                ent_addr[wr_ptr] <= {WB_Addr[AW-1:2], 2'b00};
                ent_data[wr_ptr] <= fmt_data;
                ent_be[wr_ptr]   <= fmt_be;
                wr_ptr           <= wr_ptr + 1'b1;
            end

            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end

            count <= count_next;

            if (WB_Push && (full || size_is_rsvd(WB_Size))) begin
                err <= 1'b1;
            end

            case (state)
                WB_IDLE: begin
                    // MEM_Ack is ignored here; pop is gated by WB_REQ
                    if (count != '0) begin
                        state <= WB_REQ;
                    end
                end
                WB_REQ: begin
                    if (MEM_Ack && (count_next == '0)) begin
                        state <= WB_IDLE;
                    end
                end
                default: state <= WB_IDLE;
            endcase
        end
    end

    // A pending request always has count > 0, so count alone covers in-flight.
    assign WB_Full  = full;
    assign WB_Empty = (count == '0) && (state == WB_IDLE);
    assign WB_Err   = err;

    assign MEM_Req  = (state == WB_REQ);
    assign MEM_Addr = MEM_Req ? ent_addr[rd_ptr] : '0;
    assign MEM_Data = MEM_Req ? ent_data[rd_ptr] : '0;
    assign MEM_BE   = MEM_Req ? ent_be[rd_ptr]   : WB_BE_NONE;

endmodule

// File: tb/tb_wr_buffer.sv
// ----------------------------------------------------------------------------
// tb_wr_buffer
//   Directed bench for the posted store buffer. Inputs change 1 ns after the
//   rising edge; outputs are sampled at that same point, i.e. they reflect
//   the state produced by the edge just taken.
// ----------------------------------------------------------------------------
module tb_wr_buffer;

    logic        sysclk = 1'b0;
    logic        reset;
    logic        WB_Push;
    logic [31:0] WB_Addr;
    logic [31:0] WB_Data;
    logic [1:0]  WB_Size;
    logic        WB_Full;
    logic        WB_Empty;
    logic        WB_Err;
    logic        MEM_Req;
    logic [31:0] MEM_Addr;
    logic [31:0] MEM_Data;
    logic [3:0]  MEM_BE;
    logic        MEM_Ack;

    int n_pass  = 0;
    int n_total = 0;

    always #5 sysclk = ~sysclk;

    wr_buffer #(.DEPTH(4), .AW(32), .DW(32)) dut (
        .sysclk   (sysclk),
        .reset    (reset),
        .WB_Push  (WB_Push),
        .WB_Addr  (WB_Addr),
        .WB_Data  (WB_Data),
        .WB_Size  (WB_Size),
        .WB_Full  (WB_Full),
        .WB_Empty (WB_Empty),
        .WB_Err   (WB_Err),
        .MEM_Req  (MEM_Req),
        .MEM_Addr (MEM_Addr),
        .MEM_Data (MEM_Data),
        .MEM_BE   (MEM_BE),
        .MEM_Ack  (MEM_Ack)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        WB_Push = 1'b0;
        MEM_Ack = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic set_push(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
        WB_Push = 1'b1;
        WB_Addr = a;
        WB_Data = d;
        WB_Size = s;
    endtask

    task automatic chk_head(input string tag, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] be);
        chk({tag, "_req"},  MEM_Req,  1'b1);
        chk({tag, "_addr"}, MEM_Addr, a);
        chk({tag, "_data"}, MEM_Data, d);
        chk({tag, "_be"},   MEM_BE,   be);
    endtask

    logic [31:0] exp_addr [8];
    logic [31:0] exp_data [8];
    int          k;

    initial begin
        WB_Addr = '0;
        WB_Data = '0;
        WB_Size = 2'b10;
        #1;
        do_reset();

        // reset state
        chk("rst_full",  WB_Full,  1'b0);
        chk("rst_empty", WB_Empty, 1'b1);
        chk("rst_err",   WB_Err,   1'b0);
        chk("rst_req",   MEM_Req,  1'b0);
        chk("rst_addr",  MEM_Addr, 32'h0);
        chk("rst_data",  MEM_Data, 32'h0);
        chk("rst_be",    MEM_BE,   4'h0);

        // 1: single word store, req one edge after push, ack one cycle later
        set_push(32'h0000_1000, 32'hDEAD_BEEF, 2'b10);
        tick();
        WB_Push = 1'b0;
        chk("t1_req_edge_n", MEM_Req,  1'b0);
        chk("t1_empty_low",  WB_Empty, 1'b0);
        tick();
        chk_head("t1_head", 32'h0000_1000, 32'hDEAD_BEEF, 4'b1111);
        MEM_Ack = 1'b1;
        tick();
        MEM_Ack = 1'b0;
        chk("t1_req_done",  MEM_Req,  1'b0);
        chk("t1_empty",     WB_Empty, 1'b1);
        chk("t1_addr_zero", MEM_Addr, 32'h0);

        // 2: byte and halfword formatting
        set_push(32'h0000_2003, 32'h0000_00A5, 2'b00);
        tick();
        set_push(32'h0000_2002, 32'h0000_1234, 2'b01);
        tick();
        WB_Push = 1'b0;
        chk_head("t2_byte", 32'h0000_2000, 32'hA5A5_A5A5, 4'b1000);
        MEM_Ack = 1'b1;
        tick();
        chk_head("t2_half", 32'h0000_2000, 32'h1234_1234, 4'b1100);
        tick();
        MEM_Ack = 1'b0;
        chk("t2_empty", WB_Empty, 1'b1);
        chk("t2_err",   WB_Err,   1'b0);

        // 3: fill with ack low, overflow push dropped and flagged, drain in order
        for (int i = 0; i < 4; i++) begin
            set_push(32'h0000_3000 + 32'(4 * i), 32'h3000_0000 + 32'(i), 2'b10);
            tick();
        end
        chk("t3_full_after4", WB_Full, 1'b1);
        chk("t3_err_before",  WB_Err,  1'b0);
        set_push(32'h0000_3010, 32'h3000_0004, 2'b10);
        tick();
        WB_Push = 1'b0;
        chk("t3_full_after5", WB_Full, 1'b1);
        chk("t3_err_after5",  WB_Err,  1'b1);
        for (int i = 0; i < 4; i++) begin
            chk_head($sformatf("t3_drain%0d", i), 32'h0000_3000 + 32'(4 * i),
                     32'h3000_0000 + 32'(i), 4'b1111);
            MEM_Ack = 1'b1;
            tick();
        end
        MEM_Ack = 1'b0;
        chk("t3_empty",     WB_Empty, 1'b1);
        chk("t3_err_stick", WB_Err,   1'b1);

        // 4: push into full buffer on the same edge as a pop is dropped
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_push(32'h0000_4000 + 32'(4 * i), 32'h4000_0000 + 32'(i), 2'b10);
            tick();
        end
        chk("t4_full", WB_Full, 1'b1);
        set_push(32'h0000_4010, 32'h4000_0004, 2'b10);
        MEM_Ack = 1'b1;
        tick();
        chk("t4_count3_notfull", WB_Full, 1'b0);
        chk("t4_err",            WB_Err,  1'b1);
        set_push(32'h0000_4014, 32'h4000_0005, 2'b10);
        MEM_Ack = 1'b0;
        tick();
        WB_Push = 1'b0;
        chk("t4_refull", WB_Full, 1'b1);
        chk_head("t4_d1", 32'h0000_4004, 32'h4000_0001, 4'b1111);
        MEM_Ack = 1'b1;
        tick();
        chk_head("t4_d2", 32'h0000_4008, 32'h4000_0002, 4'b1111);
        tick();
        chk_head("t4_d3", 32'h0000_400C, 32'h4000_0003, 4'b1111);
        tick();
        chk_head("t4_d5", 32'h0000_4014, 32'h4000_0005, 4'b1111);
        tick();
        MEM_Ack = 1'b0;
        chk("t4_empty", WB_Empty, 1'b1);

        // 5: ack tied high, 8 back-to-back stores, pointers wrap twice
        do_reset();
        for (int i = 0; i < 8; i++) begin
            exp_addr[i] = 32'h0000_5000 + 32'(4 * i);
            exp_data[i] = 32'h0101_0101 * 32'(i + 1);
        end
        MEM_Ack = 1'b1;
        k = 0;
        for (int c = 0; c < 14; c++) begin
            if (c < 8) set_push(exp_addr[c], exp_data[c], 2'b10);
            else       WB_Push = 1'b0;
            tick();
            if (MEM_Req) begin
                if (k < 8) begin
                    chk($sformatf("t5_addr%0d", k), MEM_Addr, exp_addr[k]);
                    chk($sformatf("t5_data%0d", k), MEM_Data, exp_data[k]);
                end else begin
                    chk("t5_extra_req", MEM_Req, 1'b0);
                end
                k++;
            end
        end
        MEM_Ack = 1'b0;
        chk("t5_req_count", 64'(k), 64'd8);
        chk("t5_err",       WB_Err,   1'b0);
        chk("t5_empty",     WB_Empty, 1'b1);

        // 6: reset during an active request discards pending entries
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_push(32'h0000_6000 + 32'(4 * i), 32'h6000_0000 + 32'(i), 2'b10);
            tick();
        end
        WB_Push = 1'b0;
        chk("t6_req_before", MEM_Req, 1'b1);
        reset = 1'b1;
        tick();
        chk("t6_req_reset",   MEM_Req,  1'b0);
        chk("t6_empty_reset", WB_Empty, 1'b1);
        chk("t6_full_reset",  WB_Full,  1'b0);
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk($sformatf("t6_noreq%0d", c), MEM_Req, 1'b0);
        end
        chk("t6_empty_after", WB_Empty, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
